// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions - data width, transmitter state
//                encoding and bit-time helper functions, common to the
//                transmitter and the matching receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Payload width, identical on both ends of a tx->rx link.
    localparam int UART_DATA_W = 8;

    // Transmitter states; PARITY is only reachable when parity is enabled.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Number of system clock cycles per line bit.
    function automatic int bit_timer_lim(input int clkfreq, input int baudrate);
        return clkfreq / baudrate;
    endfunction

    // Counter width able to hold 0..lim-1, never narrower than one bit.
    function automatic int cnt_width(input int lim);
        return (lim > 1) ? $clog2(lim) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-time generator. Counts 0..LIMIT-1 and wraps, raising
//                tick during the final count so every bit lasts exactly
//                LIMIT cycles. clear holds the count at zero so a new frame
//                always starts on a fresh bit boundary.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int LIMIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int                 c_cnt_w = cnt_width(LIMIT);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(LIMIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    assign tick = (r_cnt == c_last);

    // Free-running bit timer, restarted by clear and wrapped on tick.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter, 8 data bits LSB first, idle-high line,
//                1 or 2 stop bits. One-cycle start strobe in, one-cycle done
//                tick out. Optional parity bit enabled by defining the
//                macro UART_TX_PARITY_EN (even or odd via c_parity_odd).
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int c_clkfreq    = 100_000_000,
    parameter int c_baudrate   = 115_200,
    parameter int c_stopbits   = 1,
    parameter int c_parity_odd = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] din_i,
    input  logic                   tx_start_i,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   tx_done_tick_o
);

    localparam int               c_bittimerlim = bit_timer_lim(c_clkfreq, c_baudrate);
    localparam int               c_idx_w       = $clog2(UART_DATA_W);
    localparam logic [c_idx_w-1:0] c_data_last = c_idx_w'(UART_DATA_W - 1);
    localparam logic [c_idx_w-1:0] c_stop_last = c_idx_w'(c_stopbits - 1);

    // Reject configurations the frame logic cannot express.
    generate
        if ((c_stopbits != 1) && (c_stopbits != 2)) begin : g_bad_stopbits
            $error("uart_tx: c_stopbits must be 1 or 2");
        end
        if ((c_parity_odd != 0) && (c_parity_odd != 1)) begin : g_bad_parity
            $error("uart_tx: c_parity_odd must be 0 or 1");
        end
        if (c_bittimerlim < 1) begin : g_bad_baud
            $error("uart_tx: c_clkfreq must be at least c_baudrate");
        end
    endgenerate

    uart_tx_state_t           r_state;
    uart_tx_state_t           w_state_next;
    logic [UART_DATA_W-1:0]   r_shreg;
    logic [UART_DATA_W-1:0]   w_shreg_next;
    logic [c_idx_w-1:0]       r_idx;
    logic [c_idx_w-1:0]       w_idx_next;
    logic                     r_tx;
    logic                     w_tx_next;
    logic                     r_done;
    logic                     w_done_next;
    logic                     w_tick;
    logic                     w_timer_clr;
`ifdef UART_TX_PARITY_EN
    logic                     r_par;
    logic                     w_par_next;
`endif

    // Timer is held at zero while idle so START always lasts a full bit.
    assign w_timer_clr = (r_state == IDLE);

    uart_baud_gen #(
        .LIMIT (c_bittimerlim)
    ) u_baud_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (w_timer_clr),
        .tick  (w_tick)
    );

    // The line and done tick come straight from flops, so they never glitch.
    assign tx_o           = r_tx;
    assign busy_o         = (r_state != IDLE);
    assign tx_done_tick_o = r_done;

    // State register and datapath flops; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_shreg <= w_shreg_next;
            r_idx   <= w_idx_next;
            r_tx    <= w_tx_next;
            r_done  <= w_done_next;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_next;
`endif
        end
    end

    // Next-state logic; w_tx_next is the level the line shows after this edge.
    always_comb begin
        w_state_next = r_state;
        w_shreg_next = r_shreg;
        w_idx_next   = r_idx;
        w_tx_next    = 1'b1;
        w_done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_next   = r_par;
`endif
        case (r_state)
            IDLE: begin
                if (tx_start_i) begin
                    w_shreg_next = din_i;
                    w_idx_next   = '0;
                    w_tx_next    = 1'b0;
                    w_state_next = START;
`ifdef UART_TX_PARITY_EN
                    // Parity is taken from the byte now, the shifter destroys it.
                    w_par_next   = (^din_i) ^ (c_parity_odd != 0);
`endif
                end
            end
            START: begin
                w_tx_next = 1'b0;
                if (w_tick) begin
                    w_tx_next    = r_shreg[0];
                    w_state_next = DATA;
                end
            end
            DATA: begin
                w_tx_next = r_shreg[0];
                if (w_tick) begin
                    if (r_idx == c_data_last) begin
                        w_idx_next   = '0;
`ifdef UART_TX_PARITY_EN
                        w_tx_next    = r_par;
                        w_state_next = PARITY;
`else
                        w_tx_next    = 1'b1;
                        w_state_next = STOP;
`endif
                    end else begin
                        w_idx_next   = r_idx + 1'b1;
                        w_shreg_next = r_shreg >> 1;
                        w_tx_next    = r_shreg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_tx_next = r_par;
                if (w_tick) begin
                    w_tx_next    = 1'b1;
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                w_tx_next = 1'b1;
                if (w_tick) begin
                    if (r_idx == c_stop_last) begin
                        w_idx_next   = '0;
                        w_done_next  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_idx_next   = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
